lidar_motor_ctrl: RTL and testbench
===================================

Name: lidar_motor_ctrl

Overview:
- Avalon-MM slave controller for the lidar spindle motor.
- Replaces a bare enable bit with a sequenced enable and soft-start/soft-stop PWM duty ramp, so the motor never steps from 0 to full duty.
- Drives motor_en and motor_pwm to the motor driver.
- Exposes run state and current duty to the Nios for monitoring.

Parameters:
- PWM_BITS, 8, width of duty and PWM counter; PWM period = 2^PWM_BITS clk cycles.
- DIV_BITS, 16, width of ramp prescaler register.
- WDT_CYCLES, 50000000, watchdog timeout in clk cycles (only used with the optional feature).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- address  in  2  register select.
- chipselect  in  1  Avalon chipselect.
- write_n  in  1  Avalon write strobe, active-low.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational, zero wait/read latency.
- motor_en  out  1  driver enable.
- motor_pwm  out  1  PWM drive.

Behaviour:
- Reset is reset_n, asynchronous, active-low; clock is clk.
- Reset values: all registers 0, state IDLE, motor_en=0, motor_pwm=0, readdata=0.
- Register map (write = chipselect & ~write_n):
  - addr0 CTRL: bit0 enable, RW.
  - addr1 TARGET: [PWM_BITS-1:0] target duty, RW.
  - addr2 RAMP_DIV: [DIV_BITS-1:0] cycles per duty step, RW; value 0 behaves as 1.
  - addr3 STATUS (RO except W1C bit3): [1:0] state, bit2 at_target (cur_duty==TARGET), bit3 wdt_tripped, [8+PWM_BITS-1:8] cur_duty.
  - Unused readdata bits read 0.
- Register writes take effect the cycle after the write strobe.
- Prescaler:
  - Counts 0..div-1, emitting a 1-cycle step tick at div-1.
  - Cleared on every state transition and on any write to RAMP_DIV.
- State encoding: IDLE=0, RAMP=1, RUN=2, STOP=3.
- IDLE:
  - cur_duty=0, motor_en=0.
  - enable=1 -> RAMP.
- RAMP:
  - motor_en=1.
  - Each tick, cur_duty moves by 1 toward TARGET, up or down.
  - cur_duty==TARGET -> RUN.
  - enable=0 -> STOP, which takes priority over reaching target.
- RUN:
  - motor_en=1, cur_duty held.
  - TARGET!=cur_duty -> RAMP.
  - enable=0 -> STOP.
- STOP:
  - motor_en=1.
  - Each tick, cur_duty decrements by 1.
  - Tick while cur_duty==1, or entry with cur_duty==0 -> IDLE; cur_duty==0 is checked before waiting for a tick.
  - enable=1 during STOP -> RAMP, continuing from current cur_duty.
- TARGET=0 with enable=1: ramp to 0, then RUN with motor_en=1 and pwm constantly 0.
- PWM:
  - Free-running PWM_BITS counter wraps 2^PWM_BITS-1 -> 0.
  - motor_pwm registered, =1 when counter < cur_duty.
  - Duty 255 (8-bit) gives 255/256 high; duty 0 gives constant low.
- cur_duty never overflows or underflows; steps saturate at TARGET or 0.
- Reset asserted mid-ramp: immediate return to reset values, motor stops, no ramp-down.

Optional Feature:
- Macro: LIDAR_MOTOR_WDT_EN.
- Defined:
  - Watchdog counter runs while state != IDLE and is cleared by any write to CTRL.
  - On reaching WDT_CYCLES-1, CTRL.enable is cleared (-> STOP) and wdt_tripped is set, sticky.
  - Writing 1 to STATUS bit3 clears wdt_tripped.
  - A CTRL write in the trip cycle wins: enable takes written value, counter clears, no trip.
- Undefined: no counter; STATUS bit3 reads 0; STATUS writes ignored.

Decomposition:
- Package lidar_motor_pkg:
  - State enum (2-bit).
  - Register address constants CTRL/TARGET/RAMP_DIV/STATUS.
  - STATUS bit positions.
- One sub-module lidar_pwm_gen (PWM counter + compare + output register, params PWM_BITS, inputs clk/reset_n/duty, output pwm).

Test Plan:
- Reset, then read all 4 addrs -> readdata=0 each; motor_en=0, motor_pwm=0.
- RAMP_DIV=4, TARGET=10, CTRL=1 -> motor_en=1 next cycle; cur_duty increments every 4 cycles; RUN after 40 cycles; STATUS=0x0A06.
- In RUN at duty 10, write TARGET=6 -> RAMP, duty decrements to 6 in 16 cycles, RUN; 256-cycle PWM window shows exactly 6 high cycles.
- In RUN at 10, CTRL=0 -> STOP, duty reaches 0 after 40 cycles, IDLE, motor_en=0; re-enable at duty 5 during STOP -> RAMP from 5 upward.
- RAMP_DIV=0, TARGET=255 -> one step per cycle, RUN after 255 cycles; motor_pwm low 1 cycle per 256.
- With LIDAR_MOTOR_WDT_EN, WDT_CYCLES=100, enable and no further CTRL writes -> trip at cycle 100, bit3=1, STOP then IDLE; W1C clears bit3; CTRL write in trip cycle prevents trip.

Source files
------------

// File: rtl/lidar_motor_pkg.sv
// Shared types and constants for the lidar spindle motor controller.
// The optional watchdog is enabled with the LIDAR_MOTOR_WDT_EN macro.
package lidar_motor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_RUN  = 2'd2,
    ST_STOP = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_TARGET   = 2'd1;
  localparam logic [1:0] ADDR_RAMP_DIV = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;

  localparam int unsigned STAT_AT_TARGET = 2;
  localparam int unsigned STAT_WDT_TRIP  = 3;
  localparam int unsigned STAT_DUTY_LSB  = 8;

endpackage

// File: rtl/lidar_pwm_gen.sv
// Free-running PWM counter with a registered compare output.
module lidar_pwm_gen
  import lidar_motor_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm
);

  logic [PWM_BITS-1:0] cnt_q;
  logic                pwm_q;

  // Counter wraps naturally; duty 0 never asserts, full-scale duty leaves one low cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + PWM_BITS'(1);
      pwm_q <= (cnt_q < duty);
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/lidar_motor_ctrl.sv
// Avalon-MM spindle motor controller with sequenced enable and soft-start/soft-stop ramp.
// Optional watchdog auto-stop is built when LIDAR_MOTOR_WDT_EN is defined.
module lidar_motor_ctrl
  import lidar_motor_pkg::*;
#(
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned DIV_BITS   = 16,
  parameter int unsigned WDT_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        motor_en,
  output logic        motor_pwm
);

  logic                enable_q;
  logic [PWM_BITS-1:0] target_q;
  logic [DIV_BITS-1:0] div_q;
  state_e              state_q, state_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [DIV_BITS-1:0] presc_q, presc_d;
  logic                motor_en_q;

  logic                wr_en, wr_ctrl, wr_target, wr_div;
  logic [DIV_BITS-1:0] div_last;
  logic                tick;
  logic [PWM_BITS-1:0] duty_step;
  logic                wdt_trip;
  logic                wdt_tripped;
  logic [31:0]         status;
  logic                unused_inputs;

  assign wr_en     = chipselect & ~write_n;
  assign wr_ctrl   = wr_en && (address == ADDR_CTRL);
  assign wr_target = wr_en && (address == ADDR_TARGET);
  assign wr_div    = wr_en && (address == ADDR_RAMP_DIV);

  // Host-visible configuration registers; a watchdog trip drops enable unless CTRL is written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q <= 1'b0;
      target_q <= '0;
      div_q    <= '0;
    end else begin
      if (wr_ctrl)       enable_q <= writedata[0];
      else if (wdt_trip) enable_q <= 1'b0;
      if (wr_target)     target_q <= writedata[PWM_BITS-1:0];
      if (wr_div)        div_q    <= writedata[DIV_BITS-1:0];
    end
  end

  // A divider of 0 steps every cycle, same as 1.
  assign div_last  = (div_q == '0) ? '0 : div_q - DIV_BITS'(1);
  assign tick      = (presc_q == div_last);
  assign duty_step = (duty_q < target_q) ? duty_q + PWM_BITS'(1) : duty_q - PWM_BITS'(1);

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    case (state_q)
      ST_IDLE: begin
        duty_d = '0;
        if (enable_q) state_d = ST_RAMP;
      end
      ST_RAMP: begin
        if (!enable_q) begin
          state_d = ST_STOP;
        end else if (duty_q == target_q) begin
          state_d = ST_RUN;
        end else if (tick) begin
          duty_d = duty_step;
          if (duty_step == target_q) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enable_q)              state_d = ST_STOP;
        else if (duty_q != target_q) state_d = ST_RAMP;
      end
      ST_STOP: begin
        if (enable_q) begin
          state_d = ST_RAMP;
        end else if (duty_q == '0) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          duty_d = duty_q - PWM_BITS'(1);
          if (duty_q == PWM_BITS'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Every state change restarts the step interval so the first step is a full period away.
  assign presc_d = (state_d != state_q || wr_div || tick) ? '0 : presc_q + DIV_BITS'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      duty_q     <= '0;
      presc_q    <= '0;
      motor_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      presc_q    <= presc_d;
      motor_en_q <= (state_d != ST_IDLE);
    end
  end

`ifdef LIDAR_MOTOR_WDT_EN
  localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);

  logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
  logic             wdt_tripped_q;
  logic             wr_status;

  assign wr_status = wr_en && (address == ADDR_STATUS);
  assign wdt_trip  = !wr_ctrl && (state_q != ST_IDLE) &&
                     (wdt_cnt_q == WDT_W'(WDT_CYCLES - 1));
  assign wdt_cnt_d = (wr_ctrl || state_q == ST_IDLE || wdt_trip) ? '0
                                                                 : wdt_cnt_q + WDT_W'(1);

  // Trip flag is sticky; a coincident trip outranks the host clearing it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdt_cnt_q     <= '0;
      wdt_tripped_q <= 1'b0;
    end else begin
      wdt_cnt_q <= wdt_cnt_d;
      if (wdt_trip)
        wdt_tripped_q <= 1'b1;
      else if (wr_status && writedata[STAT_WDT_TRIP])
        wdt_tripped_q <= 1'b0;
    end
  end

  assign wdt_tripped   = wdt_tripped_q;
  assign unused_inputs = ^writedata;
`else
  assign wdt_trip      = 1'b0;
  assign wdt_tripped   = 1'b0;
  assign unused_inputs = ^{writedata, 32'(WDT_CYCLES)};
`endif

  // at_target is masked in IDLE so the status word reads zero out of reset.
  always_comb begin
    status                                 = '0;
    status[1:0]                            = state_q;
    status[STAT_AT_TARGET]                 = (state_q != ST_IDLE) && (duty_q == target_q);
    status[STAT_WDT_TRIP]                  = wdt_tripped;
    status[STAT_DUTY_LSB +: PWM_BITS]      = duty_q;
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:     readdata[0]            = enable_q;
      ADDR_TARGET:   readdata[PWM_BITS-1:0] = target_q;
      ADDR_RAMP_DIV: readdata[DIV_BITS-1:0] = div_q;
      default:       readdata               = status;
    endcase
  end

  lidar_pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk     (clk),
    .reset_n (reset_n),
    .duty    (duty_q),
    .pwm     (motor_pwm)
  );

  assign motor_en = motor_en_q;

endmodule

// File: tb/tb_lidar_motor_ctrl.sv
// Scoreboard bench for lidar_motor_ctrl: directed stimulus queues expectations, a monitor checks them.
// Build with LIDAR_MOTOR_WDT_EN to exercise the watchdog instead of the ramp sequences.
module tb_lidar_motor_ctrl;
  import lidar_motor_pkg::*;

  localparam int unsigned PWM_BITS   = 8;
  localparam int unsigned DIV_BITS   = 16;
  localparam int unsigned WDT_CYCLES = 100;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic [1:0]  address    = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = '0;
  logic [31:0] readdata;
  logic        motor_en;
  logic        motor_pwm;

  always #5 clk = ~clk;

  lidar_motor_ctrl #(
    .PWM_BITS   (PWM_BITS),
    .DIV_BITS   (DIV_BITS),
    .WDT_CYCLES (WDT_CYCLES)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .motor_en   (motor_en),
    .motor_pwm  (motor_pwm)
  );

  typedef enum int {K_RD, K_EN, K_PWM, K_VAL} kind_e;
  typedef struct {
    kind_e       kind;
    string       name;
    logic [31:0] mask;
    logic [31:0] exp;
    logic [31:0] act;
  } chk_t;

  chk_t sb[$];
  bit   chk_req = 1'b0;
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: consumes one expectation in each cycle the stimulus flags a check.
  always @(negedge clk) begin : monitor
    chk_t        c;
    logic [31:0] got;
    if (chk_req) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got no entry, expected one");
      end else begin
        c = sb.pop_front();
        case (c.kind)
          K_RD:    got = readdata;
          K_EN:    got = {31'b0, motor_en};
          K_PWM:   got = {31'b0, motor_pwm};
          default: got = c.act;
        endcase
        n_chk++;
        if ((got & c.mask) !== c.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%0h, expected 0x%0h", c.name, got & c.mask, c.exp);
        end
      end
    end
  end

  initial begin : time_limit
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic push_chk(input kind_e k, input string nm, input logic [31:0] m,
                          input logic [31:0] e, input logic [31:0] a);
    chk_t c;
    c.kind = k;
    c.name = nm;
    c.mask = m;
    c.exp  = e;
    c.act  = a;
    sb.push_back(c);
    chk_req = 1'b1;
    tick();
    chk_req    = 1'b0;
    chipselect = 1'b0;
  endtask

  task automatic chk_rd(input logic [1:0] a, input string nm, input logic [31:0] m,
                        input logic [31:0] e);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    push_chk(K_RD, nm, m, e, '0);
  endtask

  task automatic chk_en(input string nm, input logic e);
    push_chk(K_EN, nm, 32'h1, {31'b0, e}, '0);
  endtask

  task automatic chk_pwm(input string nm, input logic e);
    push_chk(K_PWM, nm, 32'h1, {31'b0, e}, '0);
  endtask

  task automatic chk_val(input string nm, input int act, input int e);
    push_chk(K_VAL, nm, '1, e, act);
  endtask

  // Poll STATUS until (readdata & m) == v; an expired budget is a failed check.
  task automatic wait_field(input string nm, input logic [31:0] m, input logic [31:0] v,
                            input int budget, output int t);
    bit hit;
    hit        = 1'b0;
    address    = ADDR_STATUS;
    chipselect = 1'b0;
    write_n    = 1'b1;
    for (int i = 0; i < budget && !hit; i++) begin
      #1;
      if ((readdata & m) == v) hit = 1'b1;
      else @(posedge clk);
    end
    t = cyc;
    if (!hit) chk_val({nm, "_timeout"}, 0, 1);
  endtask

  task automatic wait_state(input string nm, input state_e st, input int budget, output int t);
    wait_field(nm, 32'h3, {30'b0, st}, budget, t);
  endtask

  task automatic pwm_window(output int n);
    n = 0;
    repeat (256) begin
      tick();
      n += int'(motor_pwm);
    end
  endtask

  initial begin : stim
    int t0, t1, n;

    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    chk_rd(ADDR_CTRL,     "rst_ctrl",   '1, 32'h0);
    chk_rd(ADDR_TARGET,   "rst_target", '1, 32'h0);
    chk_rd(ADDR_RAMP_DIV, "rst_div",    '1, 32'h0);
    chk_rd(ADDR_STATUS,   "rst_status", '1, 32'h0);
    chk_en("rst_motor_en", 1'b0);
    chk_pwm("rst_motor_pwm", 1'b0);

`ifdef LIDAR_MOTOR_WDT_EN
    wr(ADDR_RAMP_DIV, 32'd4);
    wr(ADDR_TARGET, 32'd255);
    wr(ADDR_CTRL, 32'd1);
    wait_state("wdt_ramp", ST_RAMP, 10, t0);
    wait_field("wdt_trip", 32'h8, 32'h8, 300, t1);
    chk_val("wdt_trip_cycles", t1 - t0, 100);
    wait_state("wdt_stop", ST_STOP, 10, t0);
    wait_state("wdt_idle", ST_IDLE, 400, t0);
    chk_rd(ADDR_STATUS, "wdt_sticky_idle", '1, 32'h0008);
    wr(ADDR_STATUS, 32'h8);
    chk_rd(ADDR_STATUS, "wdt_w1c", '1, 32'h0000);

    wr(ADDR_CTRL, 32'd1);
    wait_state("wdt2_ramp", ST_RAMP, 10, t0);
    repeat (99) tick();
    wr(ADDR_CTRL, 32'd1);
    chk_rd(ADDR_STATUS, "wdt_ctrl_wins", 32'hB, 32'h1);
    repeat (5) tick();
    chk_rd(ADDR_STATUS, "wdt_no_late_trip", 32'hB, 32'h1);
`else
    // Soft start 0 -> 10 at four cycles per step.
    wr(ADDR_RAMP_DIV, 32'd4);
    wr(ADDR_TARGET, 32'd10);
    wr(ADDR_CTRL, 32'd1);
    wait_state("up_ramp", ST_RAMP, 10, t0);
    chk_en("up_motor_en", 1'b1);
    wait_state("up_run", ST_RUN, 100, t1);
    chk_val("up_ramp_cycles", t1 - t0, 40);
    chk_rd(ADDR_STATUS, "up_status", '1, 32'h0A06);

    // Retarget downward while running.
    wr(ADDR_TARGET, 32'd6);
    wait_state("down_ramp", ST_RAMP, 10, t0);
    wait_state("down_run", ST_RUN, 100, t1);
    chk_val("down_ramp_cycles", t1 - t0, 16);
    pwm_window(n);
    chk_val("pwm_high_duty6", n, 6);
    chk_rd(ADDR_STATUS, "down_status", '1, 32'h0606);

    // Back to 10, then soft stop to IDLE.
    wr(ADDR_TARGET, 32'd10);
    wait_state("re_ramp", ST_RAMP, 10, t0);
    wait_state("re_run", ST_RUN, 100, t1);
    chk_val("re_ramp_cycles", t1 - t0, 16);
    wr(ADDR_CTRL, 32'd0);
    wait_state("stop", ST_STOP, 10, t0);
    wait_state("stop_idle", ST_IDLE, 100, t1);
    chk_val("stop_cycles", t1 - t0, 40);
    chk_en("stop_motor_en", 1'b0);
    chk_rd(ADDR_STATUS, "stop_status", '1, 32'h0000);

    // Re-enable part-way through a soft stop.
    wr(ADDR_CTRL, 32'd1);
    wait_state("re2_run", ST_RUN, 100, t0);
    wr(ADDR_CTRL, 32'd0);
    wait_state("re2_stop", ST_STOP, 10, t0);
    wait_field("re2_duty5", 32'hFF03, 32'h0503, 100, t0);
    wr(ADDR_CTRL, 32'd1);
    wait_state("re2_ramp", ST_RAMP, 10, t0);
    chk_rd(ADDR_STATUS, "resume_at5", '1, 32'h0501);
    repeat (3) tick();
    chk_rd(ADDR_STATUS, "resume_step6", '1, 32'h0601);
    wait_state("re2_run_end", ST_RUN, 100, t0);

    // Divider 0 behaves as 1: full-scale ramp in 255 steps.
    wr(ADDR_CTRL, 32'd0);
    wait_state("fs_idle", ST_IDLE, 100, t0);
    wr(ADDR_RAMP_DIV, 32'd0);
    wr(ADDR_TARGET, 32'd255);
    wr(ADDR_CTRL, 32'd1);
    wait_state("fs_ramp", ST_RAMP, 10, t0);
    wait_state("fs_run", ST_RUN, 400, t1);
    chk_val("fs_ramp_cycles", t1 - t0, 255);
    pwm_window(n);
    chk_val("pwm_high_duty255", n, 255);

    // Target 0 while enabled: ramp down, then RUN with PWM held low.
    wr(ADDR_TARGET, 32'd0);
    wait_state("zero_ramp", ST_RAMP, 10, t0);
    wait_state("zero_run", ST_RUN, 400, t1);
    chk_val("zero_ramp_cycles", t1 - t0, 255);
    pwm_window(n);
    chk_val("pwm_high_duty0", n, 0);
    chk_en("zero_motor_en", 1'b1);
    chk_rd(ADDR_STATUS, "zero_status", '1, 32'h0006);
`endif

    // Reset in the middle of a ramp drops everything at once.
    wr(ADDR_TARGET, 32'd200);
    wr(ADDR_CTRL, 32'd1);
    wait_state("mid_ramp", ST_RAMP, 10, t0);
    repeat (10) tick();
    reset_n = 1'b0;
    #1;
    chk_en("midrst_motor_en", 1'b0);
    chk_pwm("midrst_motor_pwm", 1'b0);
    chk_rd(ADDR_CTRL,   "midrst_ctrl",   '1, 32'h0);
    chk_rd(ADDR_TARGET, "midrst_target", '1, 32'h0);
    chk_rd(ADDR_STATUS, "midrst_status", '1, 32'h0);
    reset_n = 1'b1;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
